// File: rtl/max_pool_2x2_pkg.sv
// Shared constants and types for the 2x2 fp32 max-pooling block.
// Defines the data width and the IEEE-754 single-precision field layout.
package max_pool_2x2_pkg;

  localparam int DATA_W   = 32;
  localparam int SIGN_BIT = 31;
  localparam int MAG_MSB  = 30;
  localparam int MAG_LSB  = 0;

  typedef logic [DATA_W-1:0] fp32_t;

endpackage

// File: rtl/max_pool_2x2_fp32_max.sv
// Combinational IEEE-754 single-precision max of two operands.
// Ties (including +0 vs -0) return the first operand, a.
module fp32_max
  import max_pool_2x2_pkg::*;
(
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic [DATA_W-1:0] y
);

  logic               sa;
  logic               sb;
  logic [MAG_MSB:0]   ma;
  logic [MAG_MSB:0]   mb;
  logic               b_wins;

  // b replaces a only when it is strictly greater under IEEE ordering
  always_comb begin
    sa     = a[SIGN_BIT];
    sb     = b[SIGN_BIT];
    ma     = a[MAG_MSB:MAG_LSB];
    mb     = b[MAG_MSB:MAG_LSB];
    b_wins = 1'b0;
    priority case (1'b1)
      (ma == '0) && (mb == '0): b_wins = 1'b0;
      sa != sb:                 b_wins = sa;
      !sa:                      b_wins = (mb > ma);
      default:                  b_wins = (mb < ma);
    endcase
    y = b_wins ? b : a;
  end

endmodule

// File: rtl/max_pool_2x2.sv
// Streaming 2x2 max-pool over a raster fp32 image, stride 2.
// Even rows fill a half-width line buffer; odd rows emit pooled pixels.
module max_pool_2x2
  import max_pool_2x2_pkg::*;
#(
  parameter int IMG_WIDHT  = 30,
  parameter int IMG_HEIGHT = 30
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] Data_In,
  input  logic              Valid_In,
  output logic [DATA_W-1:0] Data_Out,
  output logic              Valid_Out
);

  localparam int CW   = (IMG_WIDHT > 1) ? $clog2(IMG_WIDHT) : 1;
  localparam int RW   = (IMG_HEIGHT > 1) ? $clog2(IMG_HEIGHT) : 1;
  localparam int LB_D = (IMG_WIDHT / 2 > 0) ? IMG_WIDHT / 2 : 1;
  localparam int AW   = (LB_D > 1) ? $clog2(LB_D) : 1;

  logic [CW-1:0]     col;
  logic [RW-1:0]     row;
  logic [DATA_W-1:0] pending;
  logic [DATA_W-1:0] line_buf [LB_D];

  logic [AW-1:0]     lb_addr;
  logic [DATA_W-1:0] lb_rd;
  logic [DATA_W-1:0] h_max;
  logic [DATA_W-1:0] v_max;
  logic              col_last;
  logic              row_last;
  logic              col_odd;
  logic              row_odd;
  logic              lb_we;
  logic              out_fire;

  // position decode and line-buffer port control
  always_comb begin
    col_last = (col == CW'(IMG_WIDHT - 1));
    row_last = (row == RW'(IMG_HEIGHT - 1));
    col_odd  = col[0];
    row_odd  = row[0];
    lb_addr  = AW'(col >> 1);
    lb_we    = !rst && Valid_In && col_odd && !row_odd;
    out_fire = Valid_In && col_odd && row_odd;
    lb_rd    = line_buf[lb_addr];
  end

  fp32_max u_h_max (
    .a (pending),
    .b (Data_In),
    .y (h_max)
  );

  fp32_max u_v_max (
    .a (lb_rd),
    .b (h_max),
    .y (v_max)
  );

  // raster counters, pending operand and pooled output register
  always_ff @(posedge clk) begin
    if (rst) begin
      col       <= '0;
      row       <= '0;
      pending   <= '0;
      Data_Out  <= '0;
      Valid_Out <= 1'b0;
    end else begin
      Valid_Out <= 1'b0;
      if (Valid_In) begin
        col <= col_last ? '0 : col + 1'b1;
        if (col_last) begin
          row <= row_last ? '0 : row + 1'b1;
        end
        if (!col_odd) begin
          pending <= Data_In;
        end
        if (out_fire) begin
          Data_Out  <= v_max;
          Valid_Out <= 1'b1;
        end
      end
    end
  end

  // line buffer holds even-row horizontal maxima; never read before written
  always_ff @(posedge clk) begin
    if (lb_we) begin
      line_buf[lb_addr] <= h_max;
    end
  end

endmodule

// File: tb/tb_max_pool_2x2.sv
// Directed bench for max_pool_2x2: 4x4, 5x5 and 2x2 instances.
// Checks latency, values, data hold, gaps, odd sizes, signs and reset.
module tb_max_pool_2x2;

  logic        clk;
  logic        rst;
  logic        vin  [3];
  logic [31:0] din  [3];
  logic        vout [3];
  logic [31:0] dout [3];
  logic [31:0] last [3];

  int checks;
  int errors;

  max_pool_2x2 #(.IMG_WIDHT(4), .IMG_HEIGHT(4)) u_dut4 (
    .clk       (clk),
    .rst       (rst),
    .Data_In   (din[0]),
    .Valid_In  (vin[0]),
    .Data_Out  (dout[0]),
    .Valid_Out (vout[0])
  );

  max_pool_2x2 #(.IMG_WIDHT(5), .IMG_HEIGHT(5)) u_dut5 (
    .clk       (clk),
    .rst       (rst),
    .Data_In   (din[1]),
    .Valid_In  (vin[1]),
    .Data_Out  (dout[1]),
    .Valid_Out (vout[1])
  );

  max_pool_2x2 #(.IMG_WIDHT(2), .IMG_HEIGHT(2)) u_dut2 (
    .clk       (clk),
    .rst       (rst),
    .Data_In   (din[2]),
    .Valid_In  (vin[2]),
    .Data_Out  (dout[2]),
    .Valid_Out (vout[2])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // small positive integer to fp32 bit pattern
  function automatic logic [31:0] fp(input int n);
    int e;
    e = 0;
    while ((n >> (e + 1)) != 0) e++;
    return {1'b0, 8'(127 + e), 23'((n - (1 << e)) << (23 - e))};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic send(input int u, input logic [31:0] d,
                      input logic [31:0] ev, input bit v);
    vin[u] = 1'b1;
    din[u] = d;
    @(posedge clk);
    #1;
    vin[u] = 1'b0;
    chk($sformatf("vout%0d", u), {31'b0, vout[u]}, {31'b0, v});
    if (v) last[u] = ev;
    chk($sformatf("dout%0d", u), dout[u], last[u]);
  endtask

  task automatic idle(input int u, input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      chk($sformatf("idle_vout%0d", u), {31'b0, vout[u]}, 32'd0);
      chk($sformatf("idle_dout%0d", u), dout[u], last[u]);
    end
  endtask

  task automatic frame4(input int gap, input int upto);
    logic [31:0] ev;
    bit          v;
    for (int p = 1; p <= upto; p++) begin
      v  = 1'b1;
      ev = 32'h0;
      case (p)
        6:       ev = 32'h40C00000;
        8:       ev = 32'h41000000;
        14:      ev = 32'h41600000;
        16:      ev = 32'h41800000;
        default: v  = 1'b0;
      endcase
      send(0, fp(p), ev, v);
      if (gap > 0) idle(0, gap);
    end
  endtask

  task automatic frame5;
    logic [31:0] ev;
    bit          v;
    for (int p = 1; p <= 25; p++) begin
      v  = 1'b1;
      ev = 32'h0;
      case (p)
        7:       ev = 32'h40E00000;
        9:       ev = 32'h41100000;
        17:      ev = 32'h41880000;
        19:      ev = 32'h41980000;
        default: v  = 1'b0;
      endcase
      send(1, fp(p), ev, v);
    end
  endtask

  task automatic frame2(input logic [31:0] p0, input logic [31:0] p1,
                        input logic [31:0] p2, input logic [31:0] p3,
                        input logic [31:0] ev);
    send(2, p0, 32'h0, 1'b0);
    send(2, p1, 32'h0, 1'b0);
    send(2, p2, 32'h0, 1'b0);
    send(2, p3, ev, 1'b1);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst    = 1'b1;
    for (int u = 0; u < 3; u++) begin
      vin[u]  = 1'b0;
      din[u]  = 32'h0;
      last[u] = 32'h0;
    end
    vin[0] = 1'b1;
    din[0] = fp(100);
    repeat (2) @(posedge clk);
    #1;
    for (int u = 0; u < 3; u++) begin
      chk($sformatf("rst_vout%0d", u), {31'b0, vout[u]}, 32'd0);
      chk($sformatf("rst_dout%0d", u), dout[u], 32'h0);
    end
    vin[0] = 1'b0;
    rst    = 1'b0;

    frame4(0, 16);
    frame4(0, 16);
    frame4(3, 16);
    idle(0, 2);

    frame4(0, 7);
    vin[0] = 1'b1;
    din[0] = fp(50);
    rst    = 1'b1;
    @(posedge clk);
    #1;
    rst    = 1'b0;
    vin[0] = 1'b0;
    for (int u = 0; u < 3; u++) last[u] = 32'h0;
    chk("mid_rst_vout0", {31'b0, vout[0]}, 32'd0);
    chk("mid_rst_dout0", dout[0], 32'h0);
    frame4(0, 16);
    idle(0, 2);

    frame5();
    frame5();
    idle(1, 4);

    frame2(32'hC0400000, 32'hBF800000, 32'hC0000000, 32'hC0A00000,
           32'hBF800000);
    frame2(32'h80000000, 32'h00000000, 32'h80000000, 32'h80000000,
           32'h80000000);
    frame2(32'h00000000, 32'h80000000, 32'h80000000, 32'h80000000,
           32'h00000000);
    frame2(fp(5), fp(3), fp(4), fp(1), 32'h40A00000);
    frame2(fp(1), fp(2), 32'h7F800000, 32'hFF800000, 32'h7F800000);
    frame2(32'hBF800000, 32'h3F800000, 32'hFF800000, 32'hC0000000,
           32'h3F800000);
    idle(2, 2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/max_pool_2x2.md
MAX_POOL_2X2 -- requirements
Module: max_pool_2x2

Interface
REQ-001 The block SHALL have parameter IMG_WIDHT, default 30, meaning input frame width in pixels.
REQ-002 The block SHALL have parameter IMG_HEIGHT, default 30, meaning input frame height in pixels.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all logic on its rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-005 The block SHALL have port Data_In, input, 32 bits: IEEE-754 single-precision pixel, raster order.
REQ-006 The block SHALL have port Valid_In, input, 1 bit: Data_In is valid this cycle.
REQ-007 The block SHALL have port Data_Out, output, 32 bits: pooled IEEE-754 single-precision pixel.
REQ-008 The block SHALL have port Valid_Out, output, 1 bit: Data_Out is valid this cycle, one-cycle pulse per pooled pixel.

Function
REQ-009 The block SHALL treat each Valid_In=1 cycle as exactly one pixel; Valid_In=0 cycles are gaps and SHALL NOT advance any counter.
REQ-010 The block SHALL keep a column counter (0..IMG_WIDHT-1) and a row counter (0..IMG_HEIGHT-1), both advancing on accepted pixels and both wrapping to 0 at frame end with no idle cycle.
REQ-011 On an even-column pixel, the block SHALL register it as the pending horizontal operand.
REQ-012 On an odd-column pixel of an even row, the block SHALL write max(pending, Data_In) into line-buffer entry col/2; the buffer depth SHALL be IMG_WIDHT/2.
REQ-013 On an odd-column pixel of an odd row, the block SHALL compute max(line_buffer[col/2], max(pending, Data_In)) and register it into Data_Out.
REQ-014 Valid_Out SHALL assert on the cycle after the accepting edge of the odd-row, odd-column pixel (latency 1 clock) and SHALL be 0 on all other cycles.
REQ-015 Data_Out SHALL hold its last value while Valid_Out=0.
REQ-016 Output SHALL be (IMG_WIDHT/2) x (IMG_HEIGHT/2) pixels per frame, in raster order.
REQ-017 If IMG_WIDHT is odd, the last column SHALL be consumed but ignored; if IMG_HEIGHT is odd, the last row SHALL be consumed but ignored.
REQ-018 max(a,b) SHALL use IEEE ordering: differing signs -> the positive operand; both positive -> the larger magnitude; both negative -> the smaller magnitude; +0 and -0 SHALL compare equal.
REQ-019 On a tie, max SHALL return the earlier operand (line buffer before the horizontal pair, pending before Data_In).
REQ-020 NaN and infinity inputs SHALL be compared by bit pattern under REQ-018 with no special handling.
REQ-021 The block SHALL have no backpressure; a new pixel SHALL be accepted every cycle Valid_In=1, including back-to-back across frame boundaries.

Reset
REQ-022 With rst=1 at a rising edge, the row/column counters, pending register, Data_Out and Valid_Out SHALL all become 0.
REQ-023 Line-buffer contents need not be reset; every entry is written on an even row before it is read.
REQ-024 A reset mid-frame SHALL discard the partial frame; the first pixel accepted after reset SHALL be pixel (0,0).
REQ-025 Valid_In SHALL be ignored on cycles where rst=1.

Structure
REQ-026 The shared package SHALL hold the 32-bit data width constant and the fp32 field positions (sign bit 31, magnitude bits 30:0).
REQ-027 The fp32 comparison SHALL be a single combinational sub-module, fp32_max, with two data inputs and one data output (ties -> first input), instantiated twice.
REQ-028 The line buffer SHALL be inferable as distributed or block RAM: one write port, one read port, both addressed by col/2.

Verification
REQ-029 4x4 frame, pixels 1.0..16.0 in raster order, continuous Valid_In -> four Valid_Out pulses carrying 6.0, 8.0, 14.0, 16.0; each pulse 1 cycle after pixels 6, 8, 14, 16 are accepted.
REQ-030 Sign handling: 2x2 frame {-3.0, -1.0, -2.0, -5.0} -> -1.0 (0xBF800000); 2x2 frame {-0.0, +0.0, -0.0, -0.0} -> 0x80000000.
REQ-031 Gaps: the REQ-029 frame with Valid_In=0 for 3 cycles after every pixel -> same four values; Data_Out stable between pulses.
REQ-032 Odd size: IMG_WIDHT=5, IMG_HEIGHT=5, pixels 1.0..25.0 -> outputs 7.0, 9.0, 17.0, 19.0 and nothing more; a second frame sent back-to-back produces the same sequence.
REQ-033 Reset mid-frame: rst=1 for one cycle after pixel 7 of a 4x4 frame, then a full new frame -> Valid_Out=0 in the cycle after reset; then exactly the four REQ-029 results for the new frame.
